player_input_hub: RTL

PLAYER_INPUT_HUB -- requirements
Module: player_input_hub

---
 rtl/player_input_pkg.sv | 19 +
 rtl/input_debounce_ch.sv | 70 +++++++
 rtl/player_input_hub.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/player_input_pkg.sv
// Shared defaults and the queued event record for player_input_hub.
// Record fields are sized for the largest supported build (16 channels, 16-bit values).
package player_input_pkg;

  localparam int NUM_CH_DEF     = 6;
  localparam int VAL_W_DEF      = 3;
  localparam int DB_MAX_DEF     = 999_999;
  localparam int FIFO_DEPTH_DEF = 8;

  localparam int EV_CH_W  = 4;
  localparam int EV_VAL_W = 16;

  typedef struct packed {
    logic [EV_CH_W-1:0]  ch;
    logic [EV_VAL_W-1:0] val;
    logic                rel;
  } ev_rec_t;

endpackage

// File: rtl/input_debounce_ch.sv
// One player channel: 2-FF synchronisers for press line and value, plus counter debounce.
// o_rise/o_fall pulse in the cycle whose clock edge flips the stable level.
module input_debounce_ch
  import player_input_pkg::*;
#(
  parameter int VAL_W  = VAL_W_DEF,
  parameter int DB_MAX = DB_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_btn_raw,
  input  logic [VAL_W-1:0] i_val_raw,
  output logic             o_level,
  output logic             o_rise,
  output logic             o_fall,
  output logic [VAL_W-1:0] o_val_sync
);

  localparam int CNT_W = (DB_MAX < 1) ? 1 : $clog2(DB_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             r_btn_meta;
  logic             r_btn_sync;
  logic [VAL_W-1:0] r_val_meta;
  logic [VAL_W-1:0] r_val_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;

  logic w_mismatch;
  logic w_flip;

  assign w_mismatch = (r_btn_sync != r_level);
  assign w_flip     = w_mismatch && (r_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_meta <= 1'b0;
      r_btn_sync <= 1'b0;
      r_val_meta <= '0;
      r_val_sync <= '0;
    end else begin
      r_btn_meta <= i_btn_raw;
      r_btn_sync <= r_btn_meta;
      r_val_meta <= i_val_raw;
      r_val_sync <= r_val_meta;
    end
  end

  // Any cycle where the synced line agrees with the stable level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (w_flip) begin
      r_cnt   <= '0;
      r_level <= ~r_level;
    end else if (w_mismatch) begin
      r_cnt   <= r_cnt + CNT_ONE;
    end else begin
      r_cnt   <= '0;
    end
  end

  assign o_level    = r_level;
  assign o_rise     = w_flip & ~r_level;
  assign o_fall     = w_flip & r_level;
  assign o_val_sync = r_val_sync;

endmodule

// File: rtl/player_input_hub.sv
// Debounced player buttons -> per-channel pending slot -> lowest-index drain -> show-ahead queue.
// Define PLAYER_INPUT_HUB_RELEASE_EN to also queue release events (ev_rel=1); default: presses only.
module player_input_hub
  import player_input_pkg::*;
#(
  parameter int NUM_CH     = NUM_CH_DEF,
  parameter int VAL_W      = VAL_W_DEF,
  parameter int DB_MAX     = DB_MAX_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH-1:0]           btn_raw,
  input  logic [NUM_CH*VAL_W-1:0]     val_raw,
  input  logic                        lock,
  output logic                        ev_valid,
  input  logic                        ev_ready,
  output logic [$clog2(NUM_CH)-1:0]   ev_ch,
  output logic [VAL_W-1:0]            ev_val,
  output logic                        ev_rel,
  output logic [NUM_CH-1:0]           btn_level,
  output logic [$clog2(FIFO_DEPTH):0] ev_count,
  output logic                        ovf,
  input  logic                        clr_ovf
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [NUM_CH-1:0] w_level;
  logic [NUM_CH-1:0] w_rise;
  logic [NUM_CH-1:0] w_fall;
  logic [VAL_W-1:0]  w_val_sync [NUM_CH];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      input_debounce_ch #(
        .VAL_W  (VAL_W),
        .DB_MAX (DB_MAX)
      ) u_db (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_btn_raw  (btn_raw[gi]),
        .i_val_raw  (val_raw[gi*VAL_W +: VAL_W]),
        .o_level    (w_level[gi]),
        .o_rise     (w_rise[gi]),
        .o_fall     (w_fall[gi]),
        .o_val_sync (w_val_sync[gi])
      );
    end
  endgenerate

  logic [NUM_CH-1:0] w_req;
  logic [NUM_CH-1:0] w_req_rel;

`ifdef PLAYER_INPUT_HUB_RELEASE_EN
  assign w_req     = (w_rise | w_fall) & {NUM_CH{~lock}};
  assign w_req_rel = w_fall;
`else
  logic w_unused_fall;
  assign w_req         = w_rise & {NUM_CH{~lock}};
  assign w_req_rel     = '0;
  assign w_unused_fall = |w_fall;
`endif

  logic [NUM_CH-1:0] r_pend;
  logic [NUM_CH-1:0] r_prel;
  logic [VAL_W-1:0]  r_pval [NUM_CH];
  logic              r_ovf;

  ev_rec_t           r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;

  logic              w_drain_any;
  logic [CH_W-1:0]   w_drain_idx;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic [NUM_CH-1:0] w_set;
  logic [NUM_CH-1:0] w_drop;
  logic [NUM_CH-1:0] w_clr;
  ev_rec_t           w_wr_rec;
  ev_rec_t           w_head;
  logic              w_unused_head;

  // Fixed priority: the lowest-index pending channel wins the single queue write port.
  always_comb begin
    w_drain_any = 1'b0;
    w_drain_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_drain_any = 1'b1;
        w_drain_idx = CH_W'(i);
      end
    end
  end

  assign w_full = (r_count == FULL_CNT);
  assign w_pop  = ev_valid & ev_ready;
  assign w_push = w_drain_any & (~w_full | w_pop);
  assign w_set  = w_req & ~r_pend;
  assign w_drop = w_req & r_pend;

  always_comb begin
    w_clr = '0;
    if (w_push) begin
      w_clr[w_drain_idx] = 1'b1;
    end
  end

  always_comb begin
    w_wr_rec     = '0;
    w_wr_rec.ch  = EV_CH_W'(w_drain_idx);
    w_wr_rec.val = EV_VAL_W'(r_pval[w_drain_idx]);
    w_wr_rec.rel = r_prel[w_drain_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_prel <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_set;
      r_prel <= (r_prel & ~w_set) | (w_req_rel & w_set);
    end
  end

  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_pval
      always_ff @(posedge clk) begin
        if (w_set[gi]) begin
          r_pval[gi] <= w_val_sync[gi];
        end
      end
    end
  endgenerate

  // A drop in the same cycle as clr_ovf keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (|w_drop) begin
      r_ovf <= 1'b1;
    end else if (clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_rec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head        = r_mem[r_rd_ptr];
  assign w_unused_head = ^w_head;

  assign ev_valid  = (r_count != '0);
  assign ev_ch     = ev_valid ? w_head.ch[CH_W-1:0] : '0;
  assign ev_val    = ev_valid ? w_head.val[VAL_W-1:0] : '0;
`ifdef PLAYER_INPUT_HUB_RELEASE_EN
  assign ev_rel    = ev_valid & w_head.rel;
`else
  assign ev_rel    = 1'b0;
`endif
  assign btn_level = w_level;
  assign ev_count  = r_count;
  assign ovf       = r_ovf;

endmodule
